reg_file: RTL and testbench
===========================

# reg_file

Architectural register file with rename tags, the consumer end of the reorder buffer's commit interface. It holds 32 committed integer registers and, per register, the ID of the youngest in-flight reorder-buffer entry that will write it. It sits between the issuer, which reads operands and renames destinations, and the reorder buffer, which retires one result per cycle into it.

## Interface
- NUM_REGS, 32, number of architectural registers; x0 is hardwired to zero.
- XLEN, 32, register data width.
- ROB_ID_W, 4, reorder-buffer ID width. ID 0 means "no producer / value ready". Valid IDs are 1..RO_BUFFER_SIZE.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- rdy  in  1  global enable. When low, no state changes.
- reset_from_rob_bus  in  1  misprediction flush.
- valid_from_issuer  in  1  rename request this cycle.
- rd_from_issuer  in  5  register being renamed.
- dest_from_issuer  in  ROB_ID_W  ROB entry allocated to rd.
- rs1_from_issuer, rs2_from_issuer  in  5 each  source register indices.
- qj_to_issuer, qk_to_issuer  out  ROB_ID_W each  producer tag of rs1/rs2; 0 means the value is final.
- vj_to_issuer, vk_to_issuer  out  XLEN each  committed value of rs1/rs2.
- dest_from_ro_buffer  in  ROB_ID_W  committing entry; 0 means no commit.
- rd_from_ro_buffer  in  5  commit destination register.
- value_from_ro_buffer  in  XLEN  commit value.

## Operation
- State per register r: value[r] (XLEN), tag[r] (ROB_ID_W).
- Reads are combinational: qj = tag[rs1], vj = value[rs1]; qk/vk are formed the same way from rs2. Reads return the state before this cycle's rename.
- x0: reads always return q=0 and v=0. Renames and commits to x0 are ignored.
- Commit (dest_from_ro_buffer≠0, rd_from_ro_buffer≠0):
  - value[rd] <= value_from_ro_buffer.
  - tag[rd] <= 0 only if tag[rd]==dest_from_ro_buffer, meaning no younger writer exists.
- Rename (valid_from_issuer, rd_from_issuer≠0): tag[rd] <= dest_from_issuer.
- Rename and commit on the same rd in the same cycle: the rename wins and the tag becomes dest_from_issuer. The value is still written.
- Flush (reset_from_rob_bus=1):
  - All tags are cleared to 0.
  - Any rename in that cycle is discarded.
  - A commit presented in the same cycle is still written to value[], because the ROB retires the mispredicted branch in that cycle.
- rdy=0: commit, rename and flush are all ignored. Reads stay combinational.

## Timing
- rst asserted (asynchronous): all value[] and tag[] are cleared to 0 immediately. All outputs therefore read 0.
- Writes take effect at the rising edge and are visible on the read outputs in the next cycle.
- Read latency is 0 cycles (combinational).
- Same-cycle commit/read bypass is controlled by the macro in Configuration.
- One rename and one commit are accepted per cycle. There is no back-pressure; the issuer guarantees a free ROB ID.
- Tag wrap-around: ROB IDs are reused after wrap. A stale equality match cannot occur, because an ID is reallocated only after it has committed.

## Configuration
- REG_FILE_BYPASS_EN defined:
  - If a commit this cycle has rd==rsX and tag[rsX]==dest_from_ro_buffer, that port outputs q=0 and v=value_from_ro_buffer in the same cycle.
  - Bypass is suppressed for x0.
  - Bypass is suppressed when the tag mismatches, i.e. a younger producer exists.
- Undefined: reads show pre-commit state. The issuer resolves the value through the ROB's valid_of_vj/valid_of_vk path.

## Structure
- RO_BUFFER_ID_TYPE, REG_ID_TYPE, REG_TYPE and RO_BUFFER_SIZE come from config.v.
- No new constants are local to this block.
- One sub-module, reg_file_read_port, is instantiated twice (rs1, rs2). It contains the x0 forcing and the optional bypass mux.
- Storage and the write logic stay in the top module.

## Test plan
- Reset, then read x5 → q=0, v=0. Commit dest=3, rd=5, value=0x1234 → next cycle q=0, v=0x1234.
- Rename x7→ROB 2, then rename x7→ROB 4, then commit dest=2, rd=7, value=9 → value[7]=9, tag stays 4, q=4.
- Same-cycle rename x8→ROB 6 and commit dest=5, rd=8 (tag[8] was 5) → tag[8]=6, value updated.
- Tags set on x1, x2, x3, then reset_from_rob_bus with a simultaneous commit rd=1, value=0xAA and a rename x4→ROB 7 → all tags 0, value[1]=0xAA, tag[4]=0.
- Rename x0→ROB 3 and commit rd=0, value=0xFF → x0 reads q=0, v=0. rdy=0 with a commit → no change.
- With REG_FILE_BYPASS_EN: tag[9]=5, commit dest=5, rd=9, value=0x55, rs1=9 in the same cycle → qj=0, vj=0x55. Without the macro → qj=5, vj=old value.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared types and sizes for the architectural register file.
// Optional same-cycle commit bypass is enabled by REG_FILE_BYPASS_EN.
package reg_file_pkg;

  localparam int NUM_REGS = 32;
  localparam int XLEN = 32;
  localparam int ROB_ID_W = 4;
  localparam int REG_ID_W = 5;
  localparam int RO_BUFFER_SIZE = (1 << ROB_ID_W) - 1;

  typedef logic [ROB_ID_W-1:0] ro_buffer_id_t;
  typedef logic [REG_ID_W-1:0] reg_id_t;
  typedef logic [XLEN-1:0] reg_t;

endpackage

// File: rtl/reg_file_read_port.sv
// One operand read port: x0 forcing plus the optional commit bypass.
// The bypass mux exists only when REG_FILE_BYPASS_EN is defined.
module reg_file_read_port
  import reg_file_pkg::*;
(
  input  logic          rdy,
  input  reg_id_t       rs,
  input  ro_buffer_id_t tag,
  input  reg_t          value,
  input  ro_buffer_id_t cmt_dest,
  input  reg_id_t       cmt_rd,
  input  reg_t          cmt_value,
  output ro_buffer_id_t q,
  output reg_t          v
);

  logic is_x0;

  assign is_x0 = (rs == '0);

`ifdef REG_FILE_BYPASS_EN
  logic hit;

  // Only the youngest producer's commit may resolve the operand.
  assign hit = rdy && (cmt_dest != '0) &&
               (cmt_rd == rs) && (tag == cmt_dest);

  always_comb begin
    q = tag;
    v = value;
    if (is_x0) begin
      q = '0;
      v = '0;
    end else if (hit) begin
      q = '0;
      v = cmt_value;
    end
  end
`else
  logic unused_cmt;

  assign unused_cmt = ^{rdy, cmt_dest, cmt_rd, cmt_value};

  always_comb begin
    q = tag;
    v = value;
    if (is_x0) begin
      q = '0;
      v = '0;
    end
  end
`endif

endmodule

// File: rtl/reg_file.sv
// Architectural register file with rename tags and ROB commit port.
// REG_FILE_BYPASS_EN adds a same-cycle commit-to-read bypass.
module reg_file
  import reg_file_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          rdy,
  input  logic          reset_from_rob_bus,
  input  logic          valid_from_issuer,
  input  reg_id_t       rd_from_issuer,
  input  ro_buffer_id_t dest_from_issuer,
  input  reg_id_t       rs1_from_issuer,
  input  reg_id_t       rs2_from_issuer,
  output ro_buffer_id_t qj_to_issuer,
  output ro_buffer_id_t qk_to_issuer,
  output reg_t          vj_to_issuer,
  output reg_t          vk_to_issuer,
  input  ro_buffer_id_t dest_from_ro_buffer,
  input  reg_id_t       rd_from_ro_buffer,
  input  reg_t          value_from_ro_buffer
);

  reg_t          value_q [NUM_REGS];
  ro_buffer_id_t tag_q   [NUM_REGS];

  logic commit;
  logic rename;

  assign commit = (dest_from_ro_buffer != '0) &&
                  (rd_from_ro_buffer != '0);
  assign rename = valid_from_issuer &&
                  (rd_from_issuer != '0);

  // Later assignments win: flush over rename over commit tag clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        value_q[i] <= '0;
        tag_q[i]   <= '0;
      end
    end else if (rdy) begin
      if (commit) begin
        value_q[rd_from_ro_buffer] <= value_from_ro_buffer;
        if (tag_q[rd_from_ro_buffer] == dest_from_ro_buffer)
          tag_q[rd_from_ro_buffer] <= '0;
      end
      if (reset_from_rob_bus) begin
        for (int i = 0; i < NUM_REGS; i++)
          tag_q[i] <= '0;
      end else if (rename) begin
        tag_q[rd_from_issuer] <= dest_from_issuer;
      end
    end
  end

  reg_file_read_port u_rs1 (
    .rdy       (rdy),
    .rs        (rs1_from_issuer),
    .tag       (tag_q[rs1_from_issuer]),
    .value     (value_q[rs1_from_issuer]),
    .cmt_dest  (dest_from_ro_buffer),
    .cmt_rd    (rd_from_ro_buffer),
    .cmt_value (value_from_ro_buffer),
    .q         (qj_to_issuer),
    .v         (vj_to_issuer)
  );

  reg_file_read_port u_rs2 (
    .rdy       (rdy),
    .rs        (rs2_from_issuer),
    .tag       (tag_q[rs2_from_issuer]),
    .value     (value_q[rs2_from_issuer]),
    .cmt_dest  (dest_from_ro_buffer),
    .cmt_rd    (rd_from_ro_buffer),
    .cmt_value (value_from_ro_buffer),
    .q         (qk_to_issuer),
    .v         (vk_to_issuer)
  );

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios plus random
// traffic against an array-based model of the register file rules.
module tb_reg_file;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        reset_from_rob_bus;
  logic        valid_from_issuer;
  logic [4:0]  rd_from_issuer;
  logic [3:0]  dest_from_issuer;
  logic [4:0]  rs1_from_issuer;
  logic [4:0]  rs2_from_issuer;
  logic [3:0]  qj_to_issuer;
  logic [3:0]  qk_to_issuer;
  logic [31:0] vj_to_issuer;
  logic [31:0] vk_to_issuer;
  logic [3:0]  dest_from_ro_buffer;
  logic [4:0]  rd_from_ro_buffer;
  logic [31:0] value_from_ro_buffer;

  int vectors = 0;
  int errs = 0;

  logic [31:0] m_val [32];
  logic [3:0]  m_tag [32];

  reg_file dut (
    .clk                  (clk),
    .rst                  (rst),
    .rdy                  (rdy),
    .reset_from_rob_bus   (reset_from_rob_bus),
    .valid_from_issuer    (valid_from_issuer),
    .rd_from_issuer       (rd_from_issuer),
    .dest_from_issuer     (dest_from_issuer),
    .rs1_from_issuer      (rs1_from_issuer),
    .rs2_from_issuer      (rs2_from_issuer),
    .qj_to_issuer         (qj_to_issuer),
    .qk_to_issuer         (qk_to_issuer),
    .vj_to_issuer         (vj_to_issuer),
    .vk_to_issuer         (vk_to_issuer),
    .dest_from_ro_buffer  (dest_from_ro_buffer),
    .rd_from_ro_buffer    (rd_from_ro_buffer),
    .value_from_ro_buffer (value_from_ro_buffer)
  );

  always #5 clk = ~clk;

  function automatic logic bypass_hit(input logic [4:0] rs);
`ifdef REG_FILE_BYPASS_EN
    return rdy && rs != 0 && dest_from_ro_buffer != 0 &&
           rd_from_ro_buffer == rs &&
           m_tag[rs] == dest_from_ro_buffer;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [3:0] exp_q(input logic [4:0] rs);
    if (rs == 0 || bypass_hit(rs)) return 4'd0;
    return m_tag[rs];
  endfunction

  function automatic logic [31:0] exp_v(input logic [4:0] rs);
    if (rs == 0) return 32'd0;
    if (bypass_hit(rs)) return value_from_ro_buffer;
    return m_val[rs];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_val[i] = 0;
      m_tag[i] = 0;
    end
  endtask

  task automatic model_edge();
    logic [3:0] t;
    if (!rdy) return;
    if (dest_from_ro_buffer != 0 && rd_from_ro_buffer != 0) begin
      t = m_tag[rd_from_ro_buffer];
      m_val[rd_from_ro_buffer] = value_from_ro_buffer;
      if (t == dest_from_ro_buffer) m_tag[rd_from_ro_buffer] = 0;
    end
    if (reset_from_rob_bus) begin
      for (int i = 0; i < 32; i++) m_tag[i] = 0;
    end else if (valid_from_issuer && rd_from_issuer != 0) begin
      m_tag[rd_from_issuer] = dest_from_issuer;
    end
  endtask

  task automatic idle();
    rdy = 1;
    reset_from_rob_bus = 0;
    valid_from_issuer = 0;
    rd_from_issuer = 0;
    dest_from_issuer = 0;
    rs1_from_issuer = 0;
    rs2_from_issuer = 0;
    dest_from_ro_buffer = 0;
    rd_from_ro_buffer = 0;
    value_from_ro_buffer = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_edge();
    #1;
  endtask

  task automatic rename(input logic [4:0] rd, input logic [3:0] id);
    idle();
    valid_from_issuer = 1;
    rd_from_issuer = rd;
    dest_from_issuer = id;
    tick();
  endtask

  task automatic test_reset();
    idle();
    rs1_from_issuer = 5;
    rs2_from_issuer = 31;
    #1;
    vectors++;
    if (qj_to_issuer !== 0 || vj_to_issuer !== 0) begin
      errs++;
      $display("FAIL reset_x5: q=%0d v=%0h want 0/0",
               qj_to_issuer, vj_to_issuer);
    end
    vectors++;
    if (qk_to_issuer !== 0 || vk_to_issuer !== 0) begin
      errs++;
      $display("FAIL reset_x31: q=%0d v=%0h want 0/0",
               qk_to_issuer, vk_to_issuer);
    end
  endtask

  task automatic test_commit();
    idle();
    dest_from_ro_buffer = 3;
    rd_from_ro_buffer = 5;
    value_from_ro_buffer = 32'h1234;
    tick();
    idle();
    rs1_from_issuer = 5;
    #1;
    vectors++;
    if (qj_to_issuer !== 0 || vj_to_issuer !== 32'h1234) begin
      errs++;
      $display("FAIL commit: q=%0d v=%0h want 0/1234",
               qj_to_issuer, vj_to_issuer);
    end
  endtask

  task automatic test_younger_writer();
    rename(7, 2);
    rename(7, 4);
    idle();
    dest_from_ro_buffer = 2;
    rd_from_ro_buffer = 7;
    value_from_ro_buffer = 9;
    tick();
    idle();
    rs2_from_issuer = 7;
    #1;
    vectors++;
    if (qk_to_issuer !== 4 || vk_to_issuer !== 9) begin
      errs++;
      $display("FAIL younger: q=%0d v=%0h want 4/9",
               qk_to_issuer, vk_to_issuer);
    end
  endtask

  task automatic test_same_cycle();
    rename(8, 5);
    idle();
    valid_from_issuer = 1;
    rd_from_issuer = 8;
    dest_from_issuer = 6;
    dest_from_ro_buffer = 5;
    rd_from_ro_buffer = 8;
    value_from_ro_buffer = 32'h77;
    tick();
    idle();
    rs1_from_issuer = 8;
    #1;
    vectors++;
    if (qj_to_issuer !== 6 || vj_to_issuer !== 32'h77) begin
      errs++;
      $display("FAIL same_cycle: q=%0d v=%0h want 6/77",
               qj_to_issuer, vj_to_issuer);
    end
  endtask

  task automatic test_flush();
    rename(1, 1);
    rename(2, 2);
    rename(3, 3);
    idle();
    reset_from_rob_bus = 1;
    dest_from_ro_buffer = 1;
    rd_from_ro_buffer = 1;
    value_from_ro_buffer = 32'hAA;
    valid_from_issuer = 1;
    rd_from_issuer = 4;
    dest_from_issuer = 7;
    tick();
    idle();
    rs1_from_issuer = 1;
    rs2_from_issuer = 4;
    #1;
    vectors++;
    if (qj_to_issuer !== 0 || vj_to_issuer !== 32'hAA) begin
      errs++;
      $display("FAIL flush_x1: q=%0d v=%0h want 0/aa",
               qj_to_issuer, vj_to_issuer);
    end
    vectors++;
    if (qk_to_issuer !== 0) begin
      errs++;
      $display("FAIL flush_x4: q=%0d want 0", qk_to_issuer);
    end
    rs1_from_issuer = 2;
    rs2_from_issuer = 3;
    #1;
    vectors++;
    if (qj_to_issuer !== 0 || qk_to_issuer !== 0) begin
      errs++;
      $display("FAIL flush_x2x3: qj=%0d qk=%0d want 0/0",
               qj_to_issuer, qk_to_issuer);
    end
  endtask

  task automatic test_x0();
    idle();
    valid_from_issuer = 1;
    rd_from_issuer = 0;
    dest_from_issuer = 3;
    dest_from_ro_buffer = 3;
    rd_from_ro_buffer = 0;
    value_from_ro_buffer = 32'hFF;
    rs1_from_issuer = 0;
    #1;
    vectors++;
    if (qj_to_issuer !== 0 || vj_to_issuer !== 0) begin
      errs++;
      $display("FAIL x0_same: q=%0d v=%0h want 0/0",
               qj_to_issuer, vj_to_issuer);
    end
    tick();
    idle();
    rs2_from_issuer = 0;
    #1;
    vectors++;
    if (qk_to_issuer !== 0 || vk_to_issuer !== 0) begin
      errs++;
      $display("FAIL x0_after: q=%0d v=%0h want 0/0",
               qk_to_issuer, vk_to_issuer);
    end
  endtask

  task automatic test_rdy_low();
    rename(10, 5);
    idle();
    rdy = 0;
    reset_from_rob_bus = 1;
    dest_from_ro_buffer = 5;
    rd_from_ro_buffer = 10;
    value_from_ro_buffer = 32'h33;
    valid_from_issuer = 1;
    rd_from_issuer = 11;
    dest_from_issuer = 6;
    rs1_from_issuer = 10;
    #1;
    vectors++;
    if (qj_to_issuer !== 5 || vj_to_issuer !== 0) begin
      errs++;
      $display("FAIL rdy_low_same: q=%0d v=%0h want 5/0",
               qj_to_issuer, vj_to_issuer);
    end
    tick();
    idle();
    rs1_from_issuer = 10;
    rs2_from_issuer = 11;
    #1;
    vectors++;
    if (qj_to_issuer !== 5 || vj_to_issuer !== 0 ||
        qk_to_issuer !== 0) begin
      errs++;
      $display("FAIL rdy_low: qj=%0d vj=%0h qk=%0d want 5/0/0",
               qj_to_issuer, vj_to_issuer, qk_to_issuer);
    end
  endtask

  task automatic test_bypass();
    logic [3:0]  wq;
    logic [31:0] wv;
    rename(9, 5);
    idle();
    dest_from_ro_buffer = 5;
    rd_from_ro_buffer = 9;
    value_from_ro_buffer = 32'h55;
    rs1_from_issuer = 9;
    #1;
`ifdef REG_FILE_BYPASS_EN
    wq = 0;
    wv = 32'h55;
`else
    wq = 5;
    wv = 0;
`endif
    vectors++;
    if (qj_to_issuer !== wq || vj_to_issuer !== wv) begin
      errs++;
      $display("FAIL bypass_hit: q=%0d v=%0h want %0d/%0h",
               qj_to_issuer, vj_to_issuer, wq, wv);
    end
    tick();
    rename(12, 3);
    rename(12, 4);
    idle();
    dest_from_ro_buffer = 3;
    rd_from_ro_buffer = 12;
    value_from_ro_buffer = 32'h66;
    rs2_from_issuer = 12;
    #1;
    vectors++;
    if (qk_to_issuer !== 4 || vk_to_issuer !== 0) begin
      errs++;
      $display("FAIL bypass_younger: q=%0d v=%0h want 4/0",
               qk_to_issuer, vk_to_issuer);
    end
    tick();
  endtask

  task automatic test_random();
    int r;
    for (int n = 0; n < 600; n++) begin
      idle();
      rdy = ($urandom_range(0, 9) != 0);
      reset_from_rob_bus = ($urandom_range(0, 24) == 0);
      valid_from_issuer = $urandom_range(0, 1);
      rd_from_issuer = 5'($urandom_range(0, 31));
      dest_from_issuer = 4'($urandom_range(1, 15));
      rd_from_ro_buffer = 5'($urandom_range(0, 31));
      value_from_ro_buffer = $urandom;
      r = $urandom_range(0, 3);
      if (r == 0) dest_from_ro_buffer = 0;
      else if (r == 1) dest_from_ro_buffer = 4'($urandom_range(1, 15));
      else dest_from_ro_buffer = m_tag[rd_from_ro_buffer];
      rs1_from_issuer = ($urandom_range(0, 2) == 0) ?
        rd_from_ro_buffer : 5'($urandom_range(0, 31));
      rs2_from_issuer = ($urandom_range(0, 2) == 0) ?
        rd_from_issuer : 5'($urandom_range(0, 31));
      #1;
      vectors++;
      if (qj_to_issuer !== exp_q(rs1_from_issuer) ||
          vj_to_issuer !== exp_v(rs1_from_issuer)) begin
        errs++;
        $display("FAIL rand_rs1 x%0d: q=%0d v=%0h want %0d/%0h",
                 rs1_from_issuer, qj_to_issuer, vj_to_issuer,
                 exp_q(rs1_from_issuer), exp_v(rs1_from_issuer));
      end
      vectors++;
      if (qk_to_issuer !== exp_q(rs2_from_issuer) ||
          vk_to_issuer !== exp_v(rs2_from_issuer)) begin
        errs++;
        $display("FAIL rand_rs2 x%0d: q=%0d v=%0h want %0d/%0h",
                 rs2_from_issuer, qk_to_issuer, vk_to_issuer,
                 exp_q(rs2_from_issuer), exp_v(rs2_from_issuer));
      end
      tick();
    end
  endtask

  task automatic test_async_reset();
    for (int i = 1; i < 20; i++) rename(5'(i), 4'(i % 15 + 1));
    idle();
    #2;
    rst = 1;
    #1;
    model_clear();
    for (int i = 0; i < 32; i++) begin
      rs1_from_issuer = 5'(i);
      rs2_from_issuer = 5'(31 - i);
      #1;
      vectors++;
      if (qj_to_issuer !== 0 || vj_to_issuer !== 0 ||
          qk_to_issuer !== 0 || vk_to_issuer !== 0) begin
        errs++;
        $display("FAIL async_reset x%0d: qj=%0d vj=%0h qk=%0d vk=%0h",
                 i, qj_to_issuer, vj_to_issuer,
                 qk_to_issuer, vk_to_issuer);
      end
    end
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    rst = 1;
    idle();
    model_clear();
    test_reset();
    @(negedge clk);
    rst = 0;
    test_commit();
    test_younger_writer();
    test_same_cycle();
    test_flush();
    test_x0();
    test_rdy_low();
    test_bypass();
    test_random();
    test_async_reset();
    test_commit();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errs);
    $finish;
  end

endmodule
